spi_target_port: RTL and testbench
==================================

# spi_target_port

SPI target (slave) endpoint for the SPI harness: the responder end of the link driven by the SPI initiator BFM. It oversamples the initiator's SCK/SSEL/MOSI with the system clock and shifts DATA_WIDTH-bit words in both directions. Received words are presented on a one-cycle valid strobe. Transmit words are accepted through a one-entry valid/ready holding register. SPI mode 3: SCK idles high, data is driven on the falling SCK edge and sampled on the rising edge, MSB first, SSEL active-low.

## Interface
- DATA_WIDTH, 8, bits per SPI word (≥2)
- UNDERRUN_WORD, all-ones, word shifted out when no TX word is held at word start

Ports:
- clk  in  1  system clock; must be ≥4× SCK frequency
- rst_n  in  1  reset, asynchronous assert, active-low
- sck  in  1  SPI clock from initiator, asynchronous to clk
- ssel  in  1  chip select, active-low, asynchronous
- mosi  in  1  serial data from initiator
- miso  out  1  serial data to initiator
- miso_oe  out  1  MISO output enable (high while selected)
- tx_data  in  DATA_WIDTH  word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready at clk edge
- rx_data  out  DATA_WIDTH  last complete received word, held until next completion
- rx_valid  out  1  one-cycle strobe, rx_data updated
- tx_underrun  out  1  one-cycle strobe, word start with empty holding register
- busy  out  1  SSEL asserted (synchronised)

## Operation
- Synchronisers: sck, ssel and mosi each pass through 2 flops, then a third flop for edge detection. Reset values: sck chain 1, ssel chain 1, mosi chain 0.
- rise = sck_s2 & ~sck_s3; fall = ~sck_s2 & sck_s3. Edges are acted on only while ssel_s2 = 0.
- Two-state FSM:
  - IDLE → SEL on ssel_s2 = 0. On entry: bit_cnt = 0, tx_phase = 0.
  - SEL → IDLE on ssel_s2 = 1, checked before any edge in the same cycle.
- Falling edge in SEL:
  - If bit_cnt == 0 and tx_phase == 0 (word start): load tx_shift from the holding register and clear holding-full. If the holding register is empty, load UNDERRUN_WORD and pulse tx_underrun. Set tx_phase = 1.
  - At word start, miso ← MSB of the loaded word. Otherwise miso ← next bit and shift left.
- Rising edge in SEL: rx_shift ← {rx_shift[W-2:0], mosi_s2}.
  - If bit_cnt == DATA_WIDTH-1: rx_data ← the completed word, rx_valid = 1 for one cycle, bit_cnt ← 0, tx_phase ← 0.
  - Otherwise bit_cnt++.
- bit_cnt is $clog2(DATA_WIDTH) bits wide. Consecutive words under one SSEL assertion are supported; a new word begins on the next falling edge.
- Holding register:
  - tx_ready = ~full, registered.
  - Accept sets full and stores tx_data.
  - If a load and an accept occur in the same cycle, the accept cannot happen because tx_ready was 0. full clears and tx_ready rises the next cycle.
- SSEL deasserted mid-word: the partial RX word is discarded and rx_valid is not asserted. A TX word already loaded into tx_shift is lost. bit_cnt and tx_phase are cleared. The holding register is unaffected.
- miso_oe = ~ssel_s2, registered. miso holds its last value while deselected.
- Reset values: miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, busy 0, FSM IDLE, holding empty. Reset mid-transfer aborts immediately; the next transfer starts clean after SSEL is seen high and then low.

## Timing
- Input-to-action latency is 3 clk edges. An edge first sampled at clk edge k takes effect at edge k+2 and is visible after it.
- rx_valid rises 3 clk edges after the 8th SCK rise is first sampled (DATA_WIDTH = 8) and stays high for exactly 1 cycle.
- miso changes ≤3 clk after an SCK fall. The SCK high and low phases must each be ≥4 clk so MISO is stable before the initiator samples it.
- busy/miso_oe follow SSEL with a 3-clk latency. The initiator must hold SSEL low ≥4 clk before the first SCK fall.
- tx_ready drops 1 cycle after an accept and rises 1 cycle after a word-start load.

## Test plan
- Reset: hold rst_n low mid-stream → all outputs at reset values, tx_ready = 1; first word after reset is received correctly.
- Single word: preload tx 0x3C, initiator sends 0xA5 → rx_data = 0xA5 with one rx_valid pulse; initiator receives 0x3C.
- Back-to-back: tx 0x11 then 0x22 (refilled on tx_ready), initiator sends 0xF0, 0x0F under one SSEL → two rx_valid pulses with 0xF0, 0x0F; initiator receives 0x11, 0x22.
- Underrun: no tx preload, initiator sends 0x55 → tx_underrun pulses once at word start; initiator receives 0xFF; rx_data = 0x55.
- Abort: SSEL released after 5 bits of 0x81 → no rx_valid, rx_data unchanged. A following full word 0x7E is received as 0x7E with bit alignment correct.
- Timing margin: SCK half period = 4 clk, random SSEL/SCK phase vs clk, 100 random words → all match; rx_valid is always exactly 1 cycle.

Source files
------------

// File: rtl/spi_target_port.sv
// SPI mode-3 target endpoint: oversamples SCK/SSEL/MOSI on clk and shifts
// DATA_WIDTH-bit words MSB first, with a one-entry TX holding register.
module spi_target_port #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  ssel,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned     CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SEL} state_t;

  logic sck_s1, sck_s2, sck_s3;
  logic ssel_s1, ssel_s2;
  logic mosi_s1, mosi_s2;
  logic sck_rise, sck_fall;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic                  tx_phase;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1  <= 1'b1;
      sck_s2  <= 1'b1;
      sck_s3  <= 1'b1;
      ssel_s1 <= 1'b1;
      ssel_s2 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      ssel_s1 <= ssel;
      ssel_s2 <= ssel_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;

  // Holding-register "full" is kept as the inverse of tx_ready, so an accept
  // and a word-start load are mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tx_phase    <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      tx_hold     <= '0;
      tx_ready    <= 1'b1;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      miso_oe     <= ~ssel_s2;
      busy        <= ~ssel_s2;

      if (tx_valid && tx_ready) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!ssel_s2) begin
            state    <= ST_SEL;
            bit_cnt  <= '0;
            tx_phase <= 1'b0;
          end
        end
        ST_SEL: begin
          if (ssel_s2) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            tx_phase <= 1'b0;
          end else if (sck_fall) begin
            if (bit_cnt == '0 && !tx_phase) begin
              tx_phase <= 1'b1;
              if (!tx_ready) begin
                miso     <= tx_hold[DATA_WIDTH-1];
                tx_shift <= tx_hold << 1;
                tx_ready <= 1'b1;
              end else begin
                miso        <= UNDERRUN_WORD[DATA_WIDTH-1];
                tx_shift    <= UNDERRUN_WORD << 1;
                tx_underrun <= 1'b1;
              end
            end else begin
              miso     <= tx_shift[DATA_WIDTH-1];
              tx_shift <= tx_shift << 1;
            end
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s2};
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s2};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              tx_phase <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_port.sv
// Randomised scoreboard bench for spi_target_port: an initiator model drives
// mode-3 words, a monitor pops expected RX words on each rx_valid strobe.
module tb_spi_target_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b1;
  logic       ssel = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_underrun = 0;
  int exp_underrun = 0;
  int ph = 3;
  logic [7:0] last_rx = '0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] hold_q[$];

  spi_target_port #(.DATA_WIDTH(8), .UNDERRUN_WORD(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ssel(ssel), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rx_valid cycle must match the next expected word
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) n_underrun++;
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got rx_valid with data %0h expected no word", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, rx_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals();
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_tx_underrun", {31'h0, tx_underrun}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic tx_push(input logic [7:0] d);
    int k;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (tx_ready) break;
      @(negedge clk);
    end
    if (k == 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_accept: got tx_ready stuck low expected accept");
      tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      hold_q.push_back(d);
      #1 tx_valid = 1'b0;
      @(negedge clk);
      check("tx_ready_after_accept", {31'h0, tx_ready}, 32'h0);
    end
  endtask

  task automatic sel_on();
    @(posedge clk);
    #(ph) ssel = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("busy_on", {31'h0, busy}, 32'h1);
    check("miso_oe_on", {31'h0, miso_oe}, 32'h1);
  endtask

  task automatic sel_off();
    repeat (4) @(posedge clk);
    #(ph) ssel = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("busy_off", {31'h0, busy}, 32'h0);
    check("miso_oe_off", {31'h0, miso_oe}, 32'h0);
  endtask

  // Initiator: drive on SCK fall, sample MISO just before SCK rise
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half);
    logic [7:0] mi;
    logic [7:0] exp_tx;
    mi = '0;
    exp_tx = 8'hFF;
    if (hold_q.size() > 0) exp_tx = hold_q.pop_front();
    else exp_underrun++;
    for (int i = 0; i < nbits; i++) begin
      repeat (half) @(posedge clk);
      #(ph);
      sck  = 1'b0;
      mosi = mo[7-i];
      repeat (half) @(posedge clk);
      #(ph);
      mi[7-i] = miso;
      sck = 1'b1;
    end
    if (nbits == 8) begin
      rx_exp_q.push_back(mo);
      last_rx = mo;
      check("miso_word", {24'h0, mi}, {24'h0, exp_tx});
    end
  endtask

  initial begin
    // Reset values, then reset while a word is in flight
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    tx_push(8'hAB);
    sel_on();
    spi_bits(8'hC7, 3, 4);
    tx_push(8'h99);
    @(negedge clk) rst_n = 1'b0;
    ssel = 1'b1;
    sck  = 1'b1;
    mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals();
    hold_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single word
    tx_push(8'h3C);
    sel_on();
    spi_bits(8'hA5, 8, 4);
    sel_off();
    check("underrun_single", 32'(n_underrun), 32'(exp_underrun));

    // Back-to-back under one SSEL, refill on tx_ready
    tx_push(8'h11);
    sel_on();
    fork
      begin
        spi_bits(8'hF0, 8, 4);
        spi_bits(8'h0F, 8, 4);
      end
      begin : refill
        int k;
        for (k = 0; k < 400; k++) begin
          @(negedge clk);
          if (tx_ready) break;
        end
        if (k == 400) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_ready_rise: got 0 expected 1 after word start");
        end else begin
          tx_push(8'h22);
        end
      end
    join
    sel_off();
    check("underrun_b2b", 32'(n_underrun), 32'(exp_underrun));

    // Underrun
    sel_on();
    spi_bits(8'h55, 8, 4);
    sel_off();
    check("underrun_count", 32'(n_underrun), 32'(exp_underrun));
    check("underrun_expected_one", 32'(exp_underrun), 32'd1);

    // Abort after 5 bits, then a clean word
    sel_on();
    spi_bits(8'h81, 5, 4);
    sel_off();
    check("abort_rx_held", {24'h0, rx_data}, {24'h0, last_rx});
    tx_push(8'hC3);
    sel_on();
    spi_bits(8'h7E, 8, 4);
    sel_off();
    check("underrun_abort", 32'(n_underrun), 32'(exp_underrun));

    // Random words, random phase against clk, random underruns
    begin
      int sent;
      sent = 0;
      while (sent < 100) begin
        int nw;
        ph = $urandom_range(1, 9);
        nw = $urandom_range(1, 3);
        if (nw > 100 - sent) nw = 100 - sent;
        if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
        sel_on();
        for (int w = 0; w < nw; w++) begin
          if (w > 0 && $urandom_range(0, 3) != 0) tx_push(8'($urandom));
          spi_bits(8'($urandom), 8, $urandom_range(4, 5));
          sent++;
        end
        sel_off();
      end
    end

    repeat (10) @(posedge clk);
    check("rx_queue_drained", 32'(rx_exp_q.size()), 32'h0);
    check("underrun_final", 32'(n_underrun), 32'(exp_underrun));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
